// File: rtl/dmem_wr_arbiter_pkg.sv
// Shared defaults and entry layout for the per-core store buffering and
// round-robin write arbiter in front of the data memory.
package dmem_arb_pkg;

    localparam int NCORE_DEF = 8;
    localparam int AW_DEF    = 32;
    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 4;

    localparam int SRCW = $clog2(NCORE_DEF);
    localparam int PTRW = $clog2(DEPTH_DEF);

    // Buffered store: address in the upper field, write data in the lower.
    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } entry_t;

    function automatic entry_t pack_entry(input logic [AW_DEF-1:0] addr,
                                          input logic [DW_DEF-1:0] wdata);
        entry_t e;
        e.addr  = addr;
        e.wdata = wdata;
        return e;
    endfunction

endpackage

// File: rtl/dmem_wr_arbiter_wr_fifo.sv
// Small synchronous FIFO holding one core's pending stores. Pop on empty and
// push on full (without a same-cycle pop) are ignored.
module wr_fifo
    import dmem_arb_pkg::*;
#(
    parameter int W     = AW_DEF + DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify push/pop against occupancy and compute next pointers/count.
    always_comb begin
        do_pop_s  = pop && (cnt_q != {CW{1'b0}});
        // A pop in the same cycle frees the slot a push on a full FIFO needs.
        do_push_s = push && ((cnt_q != CW'(DEPTH)) || do_pop_s);
        if (do_pop_s) begin
            rd_d = rd_q + PW'(1);
        end else begin
            rd_d = rd_q;
        end
        if (do_push_s) begin
            wr_d = wr_q + PW'(1);
        end else begin
            wr_d = wr_q;
        end
        cnt_d = cnt_q + (do_push_s ? CW'(1) : CW'(0)) - (do_pop_s ? CW'(1) : CW'(0));
    end

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (do_push_s && reset) begin
            mem_q[wr_q] <= din;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q  <= {PW{1'b0}};
            wr_q  <= {PW{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == {CW{1'b0}});
    assign count = cnt_q;

endmodule

// File: rtl/dmem_wr_arbiter.sv
// Buffers each core's stores in its own FIFO and drains them one per cycle
// onto a registered dmem write port, round-robin across cores.
module dmem_wr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NCORE = NCORE_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCORE-1:0]           core_we,
    input  logic [NCORE*AW-1:0]        core_addr,
    input  logic [NCORE*DW-1:0]        core_wdata,
    output logic [NCORE-1:0]           core_full,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    output logic [$clog2(NCORE)-1:0]   mem_src,
    output logic [NCORE-1:0]           overflow,
    output logic                       idle
);

    localparam int SW = $clog2(NCORE);
    localparam int EW = AW + DW;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [EW-1:0]    fifo_dout_s  [NCORE];
    logic [CW-1:0]    fifo_count_s [NCORE];
    logic [NCORE-1:0] fifo_full_s;
    logic [NCORE-1:0] fifo_empty_s;
    logic [NCORE-1:0] grant_vec_s;
    logic             grant_valid_s;
    logic [SW-1:0]    grant_idx_s;
    logic [SW:0]      scan_s;
    logic             all_empty_s;

    logic [SW-1:0]    ptr_q, ptr_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]    mem_src_q, mem_src_d;
    logic [NCORE-1:0] overflow_q, overflow_d;

    for (genvar gi = 0; gi < NCORE; gi++) begin : g_fifo
        wr_fifo #(
            .W     (EW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (core_we[gi]),
            .pop   (grant_vec_s[gi]),
            .din   ({core_addr[gi*AW +: AW], core_wdata[gi*DW +: DW]}),
            .dout  (fifo_dout_s[gi]),
            .full  (fifo_full_s[gi]),
            .empty (fifo_empty_s[gi]),
            .count (fifo_count_s[gi])
        );
    end

    // Round-robin scan: first non-empty FIFO starting at ptr_q, wrapping.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = ptr_q;
        scan_s        = {(SW+1){1'b0}};
        for (int k = 0; k < NCORE; k++) begin
            scan_s = {1'b0, ptr_q} + (SW+1)'(k);
            if (scan_s >= (SW+1)'(NCORE)) begin
                scan_s = scan_s - (SW+1)'(NCORE);
            end else begin
                scan_s = scan_s;
            end
            if (!grant_valid_s && !fifo_empty_s[scan_s[SW-1:0]]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = scan_s[SW-1:0];
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
        grant_vec_s = {NCORE{1'b0}};
        if (grant_valid_s) begin
            grant_vec_s[grant_idx_s] = 1'b1;
        end else begin
            grant_vec_s = {NCORE{1'b0}};
        end
    end

    // Next-state for the write bus, RR pointer and sticky drop flags.
    always_comb begin
        mem_we_d    = grant_valid_s;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_src_d   = mem_src_q;
        ptr_d       = ptr_q;
        if (grant_valid_s) begin
            mem_addr_d  = fifo_dout_s[grant_idx_s][EW-1:DW];
            mem_wdata_d = fifo_dout_s[grant_idx_s][DW-1:0];
            mem_src_d   = grant_idx_s;
            if (grant_idx_s == SW'(NCORE-1)) begin
                ptr_d = {SW{1'b0}};
            end else begin
                ptr_d = grant_idx_s + SW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
        // A full FIFO still accepts a store when it is popped this cycle.
        overflow_d = overflow_q | (core_we & fifo_full_s & ~grant_vec_s);
    end

    // Output register, RR pointer and overflow flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q       <= {SW{1'b0}};
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            mem_src_q   <= {SW{1'b0}};
            overflow_q  <= {NCORE{1'b0}};
        end else begin
            ptr_q       <= ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_src_q   <= mem_src_d;
            overflow_q  <= overflow_d;
        end
    end

    // Idle needs every FIFO drained and nothing left on the bus.
    always_comb begin
        all_empty_s = 1'b1;
        for (int k = 0; k < NCORE; k++) begin
            if (fifo_count_s[k] != {CW{1'b0}}) begin
                all_empty_s = 1'b0;
            end else begin
                all_empty_s = all_empty_s;
            end
        end
    end

    assign core_full = fifo_full_s;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_src   = mem_src_q;
    assign overflow  = overflow_q;
    assign idle      = all_empty_s && !mem_we_q;

endmodule
